spi_flash_burst_reader: RTL and testbench
=========================================

// Module: spi_flash_burst_reader
// PURPOSE
//  Parametrised SPI NOR flash burst read engine. Accepts one request (address and word count),
//  issues READ/FAST_READ plus a 3- or 4-byte address, then streams WORD_BYTE_LEN-byte words
//  out over a valid/ready port with backpressure. Sits between the CPU/boot fetch logic and
//  the byte-level SPIController; supports abort and a guaranteed CS-high gap between bursts.
// PARAMETERS
//  WORD_BYTE_LEN   4  bytes per output word (1..8)
//  ADDR_BYTES      3  address bytes sent: 3 or 4
//  FAST_READ       0  0: opcode 03h/13h, no dummy; 1: opcode 0Bh/0Ch plus DUMMY_BYTES
//  DUMMY_BYTES     1  dummy bytes (FFh) after address when FAST_READ=1 (0..4)
//  BURST_MAX       16 max words per request; power of two
//  CS_IDLE_CYCLES  2  minimum clk cycles spiCs stays high after a burst ends
// PORTS
//  clk         in   1                    system clock
//  reset       in   1                    async, active-high reset
//  spiOut      out  1                    MOSI (driven by SPIController)
//  spiIn       in   1                    MISO
//  spiClk      out  1                    SCK (driven by SPIController)
//  spiCs       out  1                    chip select, active low
//  reqAddress  in   ADDR_BYTES*8         byte start address
//  reqWords    in   $clog2(BURST_MAX)    word count minus one (0 -> 1 word)
//  reqValid    in   1                    request valid
//  reqReady    out  1                    engine idle, request may be accepted
//  reqAbort    in   1                    end current burst early
//  rdData      out  WORD_BYTE_LEN*8      word; first received byte in [7:0]
//  rdValid     out  1                    rdData valid
//  rdReady     in   1                    consumer accepts rdData
//  busy        out  1                    high from accept until CS gap done
// BEHAVIOUR
//  - Reset (async): spiCs=1, reqReady=0, rdValid=0, rdData=0, busy=0, state IDLE, SPIController
//    reset; reqReady rises first clk after reset deasserts. Reset mid-burst: CS high at once, data lost.
//  - Accept on reqValid&reqReady: latch address/count, reqReady=0, busy=1; spiCs falls next cycle.
//  - States: IDLE -> CMD -> ADDR (ADDR_BYTES, MSB first) -> DUMMY (skipped if !FAST_READ or
//    DUMMY_BYTES=0) -> DATA -> END (spiCs=1, count CS_IDLE_CYCLES) -> IDLE.
//  - Opcode: ADDR_BYTES=3 -> 03h/0Bh; ADDR_BYTES=4 -> 13h/0Ch (package constants).
//  - Byte transfer to SPIController: drive dataTx, assert valid; on ready low drop valid;
//    on ready high capture dataRx. Exactly one byte in flight; DATA sends FFh.
//  - Assembly shift register gathers WORD_BYTE_LEN bytes; on completion moves to rdData if
//    !rdValid or rdReady same cycle, else engine stalls (no new byte issued, spiCs held low,
//    SCK idle) until slot frees. Effective depth 2 words; no word ever dropped or duplicated.
//  - rdValid holds with stable rdData until rdReady; falls the cycle after accept unless refilled.
//  - Burst ends after reqWords+1 words; END entered after last word moves to rdData.
//  - Address wrap past 2^(8*ADDR_BYTES)-1 is the flash's concern; engine does not track it.
//  - reqAbort: latched while busy; in-flight byte completes, partial word discarded, go END.
//    Word already in rdData still delivered. Abort with completing word same cycle: word kept.
//    reqAbort in IDLE ignored; reqValid ignored while busy.
//  - reqReady = (state==IDLE) & !reset; busy deasserts same edge reqReady rises.
//  - spiCs never low while state IDLE/END; minimum high time CS_IDLE_CYCLES always honoured.
// STRUCTURE
//  - spi_flash_pkg: opcode constants (03h,0Bh,13h,0Ch,FFh dummy), state encoding localparams.
//  - One sub-module: existing SPIController byte engine (dataTx/dataRx/valid/ready).
//  - Local: byte counter, word counter, assembly register, output register, CS gap counter.
// TESTING
//  - Defaults, addr 0x012345, reqWords=0 -> MOSI 03 01 23 45 FF*4; rdData=bytes B3B2B1B0 LE, CS high 2 clk.
//  - ADDR_BYTES=4, FAST_READ=1, DUMMY=1, addr 0x01000010 -> MOSI 0C 01 00 00 10 FF, then data.
//  - reqWords=3, rdReady low 200 clk after word0 -> word1 assembled, SCK stops, CS low; 4 words in order.
//  - reqAbort mid word2 of 8 -> words0-1 delivered, no partial, CS high, reqReady back after gap.
//  - Reset asserted during ADDR -> spiCs=1 same cycle, rdValid=0; next request runs cleanly.
//  - reqValid while busy and reqAbort in IDLE -> both ignored; scoreboard counts match exactly.

Source files
------------

// File: rtl/spi_flash_burst_reader_pkg.sv
// Shared constants for the SPI NOR flash burst reader.
//   - read opcodes for 3-/4-byte addressing, normal and fast read
//   - filler byte sent during dummy and data phases
//   - engine state encoding
package spi_flash_burst_reader_pkg;

  localparam logic [7:0] OP_READ3   = 8'h03;
  localparam logic [7:0] OP_FAST3   = 8'h0B;
  localparam logic [7:0] OP_READ4   = 8'h13;
  localparam logic [7:0] OP_FAST4   = 8'h0C;
  localparam logic [7:0] DUMMY_BYTE = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_DATA,
    ST_END
  } state_t;

  function automatic logic [7:0] read_opcode(input int addr_bytes, input bit fast);
    if (addr_bytes == 4) return fast ? OP_FAST4 : OP_READ4;
    return fast ? OP_FAST3 : OP_READ3;
  endfunction

endpackage

// File: rtl/spi_flash_burst_reader_spi_ctrl.sv
// Byte-level SPI mode-0 shifter. One byte per handshake, MSB first.
// SCK runs at clk/2: low phase presents MOSI, rising phase samples MISO.
// Ports:
//   clk, reset       system clock, async active-high reset
//   data_tx, valid   byte to send; accepted when valid & ready
//   ready            high while idle; data_rx is the last received byte
//   data_rx          received byte
//   sck, mosi, miso  SPI pins
module spi_flash_burst_reader_spi_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data_tx,
  input  logic       valid,
  output logic       ready,
  output logic [7:0] data_rx,
  output logic       sck,
  output logic       mosi,
  input  logic       miso
);

  logic       active;
  logic [2:0] bit_cnt;
  logic [7:0] tx_sh;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active  <= 1'b0;
      bit_cnt <= 3'd0;
      tx_sh   <= 8'd0;
      data_rx <= 8'd0;
      sck     <= 1'b0;
    end else if (!active) begin
      sck <= 1'b0;
      if (valid) begin
        active  <= 1'b1;
        tx_sh   <= data_tx;
        bit_cnt <= 3'd0;
      end
    end else if (!sck) begin
      sck     <= 1'b1;
      data_rx <= {data_rx[6:0], miso};
    end else begin
      sck <= 1'b0;
      if (bit_cnt == 3'd7) begin
        active <= 1'b0;
      end else begin
        bit_cnt <= bit_cnt + 3'd1;
        tx_sh   <= {tx_sh[6:0], 1'b0};
      end
    end
  end

  assign ready = !active;
  assign mosi  = tx_sh[7];

endmodule

// File: rtl/spi_flash_burst_reader.sv
// SPI NOR flash burst read engine: takes one request (address, word count - 1),
// sends opcode + address (+ dummy), then streams WORD_BYTE_LEN-byte words out
// over a valid/ready port. First received byte lands in rdData[7:0].
// Ports:
//   clk, reset                     system clock, async active-high reset
//   spiOut, spiIn, spiClk, spiCs   SPI pins (CS active low)
//   reqAddress, reqWords           request address and word count minus one
//   reqValid, reqReady, reqAbort   request handshake and early termination
//   rdData, rdValid, rdReady       output word stream
//   busy                           high from accept until the CS gap is done
//
// state    | meaning
// ---------+-----------------------------------------------
// ST_IDLE  | CS high, waiting for a request
// ST_CMD   | sending read opcode
// ST_ADDR  | sending address bytes, MSB first
// ST_DUMMY | sending dummy bytes (fast read only)
// ST_DATA  | clocking in data bytes, assembling words
// ST_END   | CS high, counting the inter-burst gap
module spi_flash_burst_reader
  import spi_flash_burst_reader_pkg::*;
#(
  parameter int unsigned WORD_BYTE_LEN  = 4,
  parameter int unsigned ADDR_BYTES     = 3,
  parameter int unsigned FAST_READ      = 0,
  parameter int unsigned DUMMY_BYTES    = 1,
  parameter int unsigned BURST_MAX      = 16,
  parameter int unsigned CS_IDLE_CYCLES = 2
) (
  input  logic                            clk,
  input  logic                            reset,
  output logic                            spiOut,
  input  logic                            spiIn,
  output logic                            spiClk,
  output logic                            spiCs,
  input  logic [ADDR_BYTES*8-1:0]         reqAddress,
  input  logic [$clog2(BURST_MAX)-1:0]    reqWords,
  input  logic                            reqValid,
  output logic                            reqReady,
  input  logic                            reqAbort,
  output logic [WORD_BYTE_LEN*8-1:0]      rdData,
  output logic                            rdValid,
  input  logic                            rdReady,
  output logic                            busy
);

  localparam int unsigned AW = ADDR_BYTES * 8;
  localparam int unsigned WW = WORD_BYTE_LEN * 8;
  localparam int unsigned CW = $clog2(BURST_MAX);

  localparam logic [7:0] OPCODE    = read_opcode(int'(ADDR_BYTES), FAST_READ != 0);
  localparam bit         USE_DUMMY = (FAST_READ != 0) && (DUMMY_BYTES != 0);

  localparam logic [2:0] ADDR_LAST  = 3'(ADDR_BYTES - 1);
  localparam logic [2:0] DUMMY_LAST = 3'((DUMMY_BYTES > 0) ? DUMMY_BYTES - 1 : 0);
  localparam logic [2:0] WORD_LAST  = 3'(WORD_BYTE_LEN - 1);
  localparam logic [7:0] GAP_LAST   = 8'((CS_IDLE_CYCLES > 0) ? CS_IDLE_CYCLES - 1 : 0);

  state_t          state, state_nx;
  logic            pend;
  logic [AW-1:0]   addr_sh;
  logic [CW-1:0]   words_left;
  logic [2:0]      byte_cnt;
  logic [WW-1:0]   asm_data;
  logic            asm_full;
  logic            abort_lat;
  logic [7:0]      gap_cnt;

  logic            tx_valid;
  logic [7:0]      tx_data;
  logic            ctrl_ready;
  logic [7:0]      ctrl_rx;

  logic in_burst, abort_now, rx_done, move, accept, last_byte;

  assign in_burst  = (state == ST_CMD) || (state == ST_ADDR) ||
                     (state == ST_DUMMY) || (state == ST_DATA);
  assign abort_now = abort_lat || reqAbort;
  assign rx_done   = pend && ctrl_ready;
  // An assembled word waits in asm_data until the output slot is free,
  // which gives a two-word buffer without ever dropping a byte.
  assign move      = asm_full && (!rdValid || rdReady);
  assign accept    = reqValid && reqReady;
  assign last_byte = (byte_cnt == 3'd0);

  assign reqReady = (state == ST_IDLE) && !reset;
  assign busy     = (state != ST_IDLE);
  assign spiCs    = !in_burst;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    tx_valid = 1'b0;
    tx_data  = DUMMY_BYTE;
    case (state)
      ST_IDLE: if (accept) state_nx = ST_CMD;
      ST_CMD, ST_ADDR, ST_DUMMY, ST_DATA: begin
        tx_valid = !pend && ctrl_ready && !asm_full && !abort_now;
        if (state == ST_CMD)       tx_data = OPCODE;
        else if (state == ST_ADDR) tx_data = addr_sh[AW-1 -: 8];
        if (rx_done) begin
          case (state)
            ST_CMD:   state_nx = ST_ADDR;
            ST_ADDR:  if (last_byte) state_nx = USE_DUMMY ? ST_DUMMY : ST_DATA;
            ST_DUMMY: if (last_byte) state_nx = ST_DATA;
            default:  ;
          endcase
        end else if (move) begin
          if ((words_left == '0) || abort_now) state_nx = ST_END;
        end else if (abort_now && !pend && !asm_full) begin
          // nothing in flight and no complete word pending: drop the partial word
          state_nx = ST_END;
        end
      end
      ST_END:  if (gap_cnt == 8'd0) state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend       <= 1'b0;
      addr_sh    <= '0;
      words_left <= '0;
      byte_cnt   <= 3'd0;
      asm_data   <= '0;
      asm_full   <= 1'b0;
      abort_lat  <= 1'b0;
      gap_cnt    <= GAP_LAST;
      rdData     <= '0;
      rdValid    <= 1'b0;
    end else begin
      if (tx_valid)     pend <= 1'b1;
      else if (rx_done) pend <= 1'b0;

      if (!in_burst)     abort_lat <= 1'b0;
      else if (reqAbort) abort_lat <= 1'b1;

      if (accept) begin
        addr_sh    <= reqAddress;
        words_left <= reqWords;
        asm_full   <= 1'b0;
      end

      if (rx_done) begin
        case (state)
          ST_CMD:  byte_cnt <= ADDR_LAST;
          ST_ADDR: begin
            addr_sh  <= addr_sh << 8;
            byte_cnt <= last_byte ? (USE_DUMMY ? DUMMY_LAST : WORD_LAST) : byte_cnt - 3'd1;
          end
          ST_DUMMY: byte_cnt <= last_byte ? WORD_LAST : byte_cnt - 3'd1;
          ST_DATA: begin
            asm_data <= WW'({ctrl_rx, asm_data} >> 8);
            if (last_byte) begin
              asm_full <= 1'b1;
              byte_cnt <= WORD_LAST;
            end else begin
              byte_cnt <= byte_cnt - 3'd1;
            end
          end
          default: ;
        endcase
      end

      if (move) begin
        rdData   <= asm_data;
        rdValid  <= 1'b1;
        asm_full <= 1'b0;
        if (words_left != '0) words_left <= words_left - CW'(1);
      end else if (rdReady) begin
        rdValid <= 1'b0;
      end

      if (state != ST_END)      gap_cnt <= GAP_LAST;
      else if (gap_cnt != 8'd0) gap_cnt <= gap_cnt - 8'd1;
    end
  end

  spi_flash_burst_reader_spi_ctrl u_spi_ctrl (
    .clk     (clk),
    .reset   (reset),
    .data_tx (tx_data),
    .valid   (tx_valid),
    .ready   (ctrl_ready),
    .data_rx (ctrl_rx),
    .sck     (spiClk),
    .mosi    (spiOut),
    .miso    (spiIn)
  );

endmodule

// File: tb/tb_spi_flash_burst_reader.sv
module tb_spi_flash_burst_reader;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  // default-parameter instance
  logic        a_spiOut, a_spiClk, a_spiCs, a_reqReady, a_rdValid, a_busy;
  logic [23:0] a_reqAddress = '0;
  logic [3:0]  a_reqWords = '0;
  logic        a_reqValid = 1'b0, a_reqAbort = 1'b0, a_rdReady = 1'b1;
  logic [31:0] a_rdData;

  // 4-byte address, fast read, one dummy byte
  logic        b_spiOut, b_spiClk, b_spiCs, b_reqReady, b_rdValid, b_busy;
  logic [31:0] b_reqAddress = '0;
  logic [3:0]  b_reqWords = '0;
  logic        b_reqValid = 1'b0, b_reqAbort = 1'b0, b_rdReady = 1'b1;
  logic [31:0] b_rdData;

  logic miso;

  spi_flash_burst_reader dut_a (
    .clk(clk), .reset(reset), .spiOut(a_spiOut), .spiIn(miso), .spiClk(a_spiClk),
    .spiCs(a_spiCs), .reqAddress(a_reqAddress), .reqWords(a_reqWords),
    .reqValid(a_reqValid), .reqReady(a_reqReady), .reqAbort(a_reqAbort),
    .rdData(a_rdData), .rdValid(a_rdValid), .rdReady(a_rdReady), .busy(a_busy)
  );

  spi_flash_burst_reader #(.ADDR_BYTES(4), .FAST_READ(1), .DUMMY_BYTES(1)) dut_b (
    .clk(clk), .reset(reset), .spiOut(b_spiOut), .spiIn(miso), .spiClk(b_spiClk),
    .spiCs(b_spiCs), .reqAddress(b_reqAddress), .reqWords(b_reqWords),
    .reqValid(b_reqValid), .reqReady(b_reqReady), .reqAbort(b_reqAbort),
    .rdData(b_rdData), .rdValid(b_rdValid), .rdReady(b_rdReady), .busy(b_busy)
  );

  // Flash model: only one DUT is ever selected at a time.
  logic sck_m, mosi_m, cs_m;
  assign sck_m  = !a_spiCs ? a_spiClk : b_spiClk;
  assign mosi_m = !a_spiCs ? a_spiOut : b_spiOut;
  assign cs_m   = a_spiCs & b_spiCs;

  int         bitn = 0;
  int         mosi_cnt = 0;
  logic [7:0] mosi_sh = '0;
  logic [7:0] mosi_log [0:63];

  always @(posedge sck_m or negedge cs_m) begin
    if (sck_m) begin
      mosi_sh = {mosi_sh[6:0], mosi_m};
      bitn++;
      if ((bitn % 8 == 0) && (mosi_cnt < 64)) begin
        mosi_log[mosi_cnt] = mosi_sh;
        mosi_cnt++;
      end
    end else begin
      bitn = 0;
      mosi_cnt = 0;
    end
  end

  // After the header, data byte k is 8'h10 + k.
  int         hdr;
  logic [7:0] dbyte;
  logic [2:0] bsel;
  always_comb begin
    hdr   = (!a_spiCs) ? 4 : 6;
    miso  = 1'b1;
    dbyte = 8'hFF;
    bsel  = 3'(7 - (bitn % 8));
    if (bitn >= hdr * 8) begin
      dbyte = 8'h10 + 8'(bitn / 8 - hdr);
      miso  = dbyte[bsel];
    end
  end

  logic [31:0] sb_q [$];
  always @(posedge clk) if (a_rdValid && a_rdReady) sb_q.push_back(a_rdData);

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic req_a(input logic [23:0] addr, input logic [3:0] nw);
    a_reqAddress = addr;
    a_reqWords   = nw;
    a_reqValid   = 1'b1;
    @(negedge clk);
    a_reqValid   = 1'b0;
  endtask

  task automatic wait_a_valid(input string tag, input int budget);
    int n = 0;
    while (!a_rdValid && n < budget) begin @(negedge clk); n++; end
    chk(tag, a_rdValid, 1);
  endtask

  task automatic wait_a_idle(input string tag, input int budget);
    int n = 0;
    while (a_busy && n < budget) begin @(negedge clk); n++; end
    chk(tag, a_busy, 0);
  endtask

  task automatic wait_sb(input string tag, input int cnt, input int budget);
    int n = 0;
    while (sb_q.size() < cnt && n < budget) begin @(negedge clk); n++; end
    chk(tag, sb_q.size() >= cnt, 1);
  endtask

  task automatic chk_mosi(input string tag, input logic [7:0] exp [], input int cnt);
    chk({tag, "_cnt"}, mosi_cnt, cnt);
    foreach (exp[i]) chk($sformatf("%s_b%0d", tag, i), mosi_log[i], exp[i]);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int toggles;
    logic prev_sck;
    logic [7:0] e1 [] = '{8'h03, 8'h01, 8'h23, 8'h45, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    logic [7:0] e2 [] = '{8'h0C, 8'h01, 8'h00, 8'h00, 8'h10, 8'hFF, 8'hFF};
    logic [7:0] e5 [] = '{8'h03, 8'h00, 8'h00, 8'h04};

    // reset state
    #1 reset = 1'b1;
    tick(3);
    chk("rst_cs", a_spiCs, 1);
    chk("rst_reqready", a_reqReady, 0);
    chk("rst_rdvalid", a_rdValid, 0);
    chk("rst_rddata", a_rdData, 0);
    chk("rst_busy", a_busy, 0);
    reset = 1'b0;
    tick(1);
    chk("rst_reqready_rise", a_reqReady, 1);

    // single word, 3-byte address, normal read
    sb_q.delete();
    req_a(24'h012345, 4'd0);
    chk("t1_busy", a_busy, 1);
    wait_a_valid("t1_valid", 300);
    chk("t1_data", a_rdData, 32'h13121110);
    n = 0;
    while (a_busy && n < 20) begin
      if (a_spiCs) n++;
      @(negedge clk);
    end
    chk("t1_cs_gap", n, 2);
    chk("t1_reqready", a_reqReady, 1);
    chk("t1_rdvalid_fall", a_rdValid, 0);
    chk_mosi("t1_mosi", e1, 8);
    chk("t1_sb_cnt", sb_q.size(), 1);
    chk("t1_sb0", sb_q[0], 32'h13121110);

    // 4-byte address, fast read with one dummy byte
    b_reqAddress = 32'h01000010;
    b_reqWords   = 4'd0;
    b_reqValid   = 1'b1;
    @(negedge clk);
    b_reqValid   = 1'b0;
    n = 0;
    while (!b_rdValid && n < 400) begin @(negedge clk); n++; end
    chk("t2_valid", b_rdValid, 1);
    chk("t2_data", b_rdData, 32'h13121110);
    n = 0;
    while (b_busy && n < 50) begin @(negedge clk); n++; end
    chk("t2_idle", b_busy, 0);
    chk_mosi("t2_mosi", e2, 10);

    // backpressure: consumer stalls 200 cycles after word0
    sb_q.delete();
    a_rdReady = 1'b0;
    req_a(24'h000100, 4'd3);
    wait_a_valid("t3_valid", 300);
    toggles = 0;
    prev_sck = a_spiClk;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (i >= 100 && a_spiClk != prev_sck) toggles++;
      prev_sck = a_spiClk;
    end
    chk("t3_sck_idle", toggles, 0);
    chk("t3_cs_low", a_spiCs, 0);
    chk("t3_hold_valid", a_rdValid, 1);
    chk("t3_hold_data", a_rdData, 32'h13121110);
    chk("t3_busy", a_busy, 1);
    chk("t3_sb_empty", sb_q.size(), 0);
    a_rdReady = 1'b1;
    wait_sb("t3_sb_wait", 4, 600);
    wait_a_idle("t3_idle", 100);
    chk("t3_sb_cnt", sb_q.size(), 4);
    chk("t3_w0", sb_q[0], 32'h13121110);
    chk("t3_w1", sb_q[1], 32'h17161514);
    chk("t3_w2", sb_q[2], 32'h1B1A1918);
    chk("t3_w3", sb_q[3], 32'h1F1E1D1C);

    // abort in the middle of word2 of an 8-word burst
    sb_q.delete();
    req_a(24'h000200, 4'd7);
    wait_sb("t4_sb_wait", 2, 600);
    tick(20);
    a_reqAbort = 1'b1;
    tick(1);
    a_reqAbort = 1'b0;
    wait_a_idle("t4_idle", 200);
    chk("t4_sb_cnt", sb_q.size(), 2);
    chk("t4_w0", sb_q[0], 32'h13121110);
    chk("t4_w1", sb_q[1], 32'h17161514);
    chk("t4_cs", a_spiCs, 1);
    chk("t4_reqready", a_reqReady, 1);
    chk("t4_rdvalid", a_rdValid, 0);

    // reset while sending the address
    req_a(24'h0ABCDE, 4'd0);
    n = 0;
    while (mosi_cnt < 1 && n < 100) begin @(negedge clk); n++; end
    tick(5);
    chk("t5_cs_pre", a_spiCs, 0);
    #2 reset = 1'b1;
    #1;
    chk("t5_cs_async", a_spiCs, 1);
    chk("t5_rdvalid", a_rdValid, 0);
    chk("t5_busy", a_busy, 0);
    chk("t5_reqready", a_reqReady, 0);
    @(negedge clk);
    reset = 1'b0;
    tick(1);
    sb_q.delete();
    req_a(24'h000004, 4'd0);
    wait_a_valid("t5_valid", 300);
    chk("t5_data", a_rdData, 32'h13121110);
    wait_a_idle("t5_idle", 50);
    chk_mosi("t5_mosi", e5, 8);
    chk("t5_sb_cnt", sb_q.size(), 1);

    // abort in IDLE and reqValid while busy are ignored
    a_reqAbort = 1'b1;
    tick(1);
    a_reqAbort = 1'b0;
    tick(1);
    sb_q.delete();
    req_a(24'h000300, 4'd1);
    a_reqAddress = 24'hFFFFFF;
    a_reqWords   = 4'd7;
    a_reqValid   = 1'b1;
    tick(30);
    a_reqValid   = 1'b0;
    wait_a_idle("t6_idle", 400);
    chk("t6_mosi_cnt", mosi_cnt, 12);
    chk("t6_sb_cnt", sb_q.size(), 2);
    chk("t6_w0", sb_q[0], 32'h13121110);
    chk("t6_w1", sb_q[1], 32'h17161514);
    tick(20);
    chk("t6_stay_idle", a_busy, 0);
    chk("t6_sb_final", sb_q.size(), 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
